// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_pkg
// Description : Shared types and constants for the configurable UART
//               transmitter: serializer state encoding, parity-mode codes,
//               data-bits decode helpers and the minimum bit divisor.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // cfg_parity encodings (code 3 is a second spelling of "none")
  localparam logic [1:0] PAR_NONE     = 2'd0;
  localparam logic [1:0] PAR_EVEN     = 2'd1;
  localparam logic [1:0] PAR_ODD      = 2'd2;
  localparam logic [1:0] PAR_NONE_ALT = 2'd3;

  // cfg_data_bits encodings
  localparam logic [1:0] BITS_5 = 2'd0;
  localparam logic [1:0] BITS_6 = 2'd1;
  localparam logic [1:0] BITS_7 = 2'd2;
  localparam logic [1:0] BITS_8 = 2'd3;

  // Smallest divisor value honoured; anything below is raised to this.
  localparam int MIN_DIV = 3;

  // Mask selecting the data bits that actually go on the line.
  function automatic logic [7:0] data_mask(input logic [1:0] code);
    logic [7:0] m;
    case (code)
      BITS_5:  m = 8'h1F;
      BITS_6:  m = 8'h3F;
      BITS_7:  m = 8'h7F;
      BITS_8:  m = 8'hFF;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Index of the last data bit sent (4..7).
  function automatic logic [2:0] last_bit_idx(input logic [1:0] code);
    return 3'd4 + {1'b0, code};
  endfunction

  function automatic logic parity_enabled(input logic [1:0] mode);
    logic en;
    case (mode)
      PAR_EVEN, PAR_ODD:      en = 1'b1;
      PAR_NONE, PAR_NONE_ALT: en = 1'b0;
      default:                en = 1'b0;
    endcase
    return en;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Synchronous single-clock FIFO with registered occupancy.
//               A push on a full FIFO is accepted when a pop happens in the
//               same cycle (level stays unchanged). Read data is the head
//               entry, available combinationally.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n (async active-low)
//               push/wdata  - write side
//               pop/rdata   - read side (pop on empty is ignored)
//               full, empty - status
//               level       - occupancy, 0..DEPTH
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_cfg
// Description : Runtime-configurable UART transmitter (5..8 data bits,
//               none/even/odd parity, 1 or 2 stop bits, programmable bit
//               time). Frame settings and the byte are captured when a frame
//               starts, so config changes mid-frame do not disturb it.
//               Build option UART_TX_CFG_FIFO_EN adds a FIFO_DEPTH-entry
//               FIFO in front of the serializer; without it a single
//               holding register is used and fifo_level reads 0.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n (async active-low)
//               cfg_div       - clocks per bit minus 1 (min 3)
//               cfg_data_bits - 0..3 => 5..8 data bits
//               cfg_parity    - 0/3 none, 1 even, 2 odd
//               cfg_stop2     - two stop bits when set
//               tx_data/tx_valid/tx_ready - byte input handshake
//               tx            - serial line, idle high, registered
//               busy          - high while a frame is on the line
//               fifo_level    - FIFO occupancy
// ============================================================================
module uart_tx_cfg #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DIV_W-1:0]            cfg_div,
  input  logic [1:0]                  cfg_data_bits,
  input  logic [1:0]                  cfg_parity,
  input  logic                        cfg_stop2,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  import uart_pkg::*;

  state_t           state;
  state_t           next_state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       bit_idx;
  logic [2:0]       last_q;
  logic             stop_idx;
  logic             stop2_q;
  logic             par_en_q;
  logic             par_q;
  logic [7:0]       data_q;
  logic             load;
  logic             avail;
  logic             bit_end;
  logic             line;
  logic             rdy_en;
  logic [7:0]       src_byte;
  logic [7:0]       src_masked;

  assign src_masked = src_byte & data_mask(cfg_data_bits);
  assign bit_end    = (cnt == div_q);

`ifdef UART_TX_CFG_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  assign tx_ready = rdy_en && !fifo_full;
  assign avail    = !fifo_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_valid && tx_ready),
    .wdata (tx_data),
    .pop   (load),
    .rdata (src_byte),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );
`else
  // data_q acts as the holding register; a byte is only taken in IDLE.
  assign tx_ready   = rdy_en && (state == ST_IDLE);
  assign avail      = tx_valid && tx_ready;
  assign src_byte   = tx_data;
  assign fifo_level = '0;
`endif

  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (avail) begin
          load       = 1'b1;
          next_state = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) next_state = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end && (bit_idx == last_q))
          next_state = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (bit_end) next_state = ST_STOP;
      end
      ST_STOP: begin
        // stop_idx reaches stop2_q on the final stop bit; chain straight
        // into the next frame when a byte is waiting.
        if (bit_end && (stop_idx == stop2_q)) begin
          if (avail) begin
            load       = 1'b1;
            next_state = ST_START;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    line = 1'b1;
    case (state)
      ST_START:  line = 1'b0;
      ST_DATA:   line = data_q[bit_idx];
      ST_PARITY: line = par_q;
      default:   line = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      div_q    <= '0;
      bit_idx  <= '0;
      last_q   <= '0;
      stop_idx <= 1'b0;
      stop2_q  <= 1'b0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      data_q   <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      rdy_en   <= 1'b0;
    end else begin
      state  <= next_state;
      rdy_en <= 1'b1;
      // Line and busy both lag the state by one clock so busy spans
      // exactly the START..last STOP clocks seen on tx.
      tx     <= line;
      busy   <= (state != ST_IDLE);
      if (load) begin
        div_q    <= (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
        data_q   <= src_masked;
        last_q   <= last_bit_idx(cfg_data_bits);
        par_en_q <= parity_enabled(cfg_parity);
        par_q    <= (^src_masked) ^ (cfg_parity == PAR_ODD);
        stop2_q  <= cfg_stop2;
        cnt      <= '0;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
      end else if (state != ST_IDLE) begin
        if (bit_end) begin
          cnt <= '0;
          if (state == ST_DATA) bit_idx  <= bit_idx + 3'd1;
          if (state == ST_STOP) stop_idx <= ~stop_idx;
        end else begin
          cnt <= cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_cfg
// Description : Self-checking bench for uart_tx_cfg. Table of frame vectors
//               with hand-computed line sequences, plus sequences for reset,
//               mid-frame reset, mid-frame divisor change, ignored offers
//               and (FIFO build) back-to-back queued frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

  localparam int DIV_W = 16;
  localparam int DEPTH = 4;
`ifdef UART_TX_CFG_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk;
  logic             rst_n;
  logic [DIV_W-1:0] cfg_div;
  logic [1:0]       cfg_data_bits;
  logic [1:0]       cfg_parity;
  logic             cfg_stop2;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx;
  logic             busy;
  logic [2:0]       fifo_level;

  int tests = 0;
  int fails = 0;

  uart_tx_cfg #(
    .DIV_W      (DIV_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_div       (cfg_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx            (tx),
    .busy          (busy),
    .fifo_level    (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] div;
    logic [1:0]  bits;
    logic [1:0]  par;
    logic        stop2;
    logic [7:0]  data;
    logic [15:0] seq;   // line bits, seq[0] goes out first
    int          nb;
    int          cpb;
  } vec_t;

  vec_t vecs[6];

  // Capture of the line, used for back-to-back frame checking.
  logic cap_en = 1'b0;
  logic cap[$];
  always @(negedge clk) if (cap_en) cap.push_back(tx);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] div, input logic [1:0] bits, input logic [1:0] par,
                      input logic st2, input logic [7:0] d);
    @(negedge clk);
    cfg_div = div; cfg_data_bits = bits; cfg_parity = par; cfg_stop2 = st2;
    tx_data = d; tx_valid = 1'b1;
    check("ready_before_accept", {31'b0, tx_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Starts at the negedge right after the accepting edge.
  task automatic check_frame(input string name, input logic [15:0] seq, input int nb,
                             input int cpb, input int new_div);
    logic ok;
    logic got;
    check($sformatf("%s_latency", name), {31'b0, tx}, 32'd1);
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      check($sformatf("%s_latency%0d", name, i), {31'b0, tx}, 32'd1);
    end
    for (int b = 0; b < nb; b++) begin
      ok  = 1'b1;
      got = seq[b];
      if (b == nb - 1) tx_valid = 1'b0;
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        if (ok && (tx !== seq[b])) begin ok = 1'b0; got = tx; end
        if (b == 0 && c == 0) begin
          check($sformatf("%s_busy", name), {31'b0, busy}, 32'd1);
          if (new_div >= 0) cfg_div = new_div[15:0];
        end
      end
      check($sformatf("%s_bit%0d", name, b), {31'b0, got}, {31'b0, seq[b]});
    end
    @(negedge clk);
    check($sformatf("%s_end_tx", name), {31'b0, tx}, 32'd1);
    check($sformatf("%s_end_busy", name), {31'b0, busy}, 32'd0);
  endtask

  function automatic logic [9:0] frame8n1(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  initial begin
    //             div    bits  par   st2   data   seq       nb  cpb
    vecs[0] = '{16'd3, 2'd3, 2'd0, 1'b0, 8'h55, 16'h02AA, 10, 4};
    vecs[1] = '{16'd7, 2'd2, 2'd1, 1'b1, 8'hFF, 16'h07FE, 11, 8};
    vecs[2] = '{16'd3, 2'd0, 2'd2, 1'b0, 8'hE3, 16'h00C6,  8, 4};
    vecs[3] = '{16'd0, 2'd1, 2'd3, 1'b0, 8'hA5, 16'h00CA,  8, 4};
    vecs[4] = '{16'd5, 2'd3, 2'd2, 1'b1, 8'h3C, 16'h0E78, 12, 6};
    vecs[5] = '{16'd1, 2'd3, 2'd1, 1'b0, 8'h01, 16'h0602, 11, 4};

    rst_n = 1'b0; cfg_div = 16'd3; cfg_data_bits = 2'd3; cfg_parity = 2'd0;
    cfg_stop2 = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_level", {29'b0, fifo_level}, 32'd0);
    check("rst_ready", {31'b0, tx_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'b0, tx_ready}, 32'd1);
    @(negedge clk);

    // Table of frames
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].div, vecs[i].bits, vecs[i].par, vecs[i].stop2, vecs[i].data);
      check_frame($sformatf("vec%0d", i), vecs[i].seq, vecs[i].nb, vecs[i].cpb, -1);
    end

    // Divisor change mid-frame: old bit time kept, new one used next frame
    send(16'd3, 2'd3, 2'd0, 1'b0, 8'h55);
    check_frame("divchg_old", 16'h02AA, 10, 4, 9);
    send(16'd9, 2'd3, 2'd0, 1'b0, 8'h55);
    check_frame("divchg_new", 16'h02AA, 10, 10, -1);

    // Reset during DATA bit 3
    send(16'd3, 2'd3, 2'd0, 1'b0, 8'h55);
    repeat (18) @(negedge clk);
    check("midrst_pre_tx", {31'b0, tx}, 32'd0);
    check("midrst_pre_busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", {31'b0, tx}, 32'd1);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_level", {29'b0, fifo_level}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(16'd3, 2'd3, 2'd0, 1'b0, 8'h55);
    check_frame("after_rst", 16'h02AA, 10, 4, -1);

`ifndef UART_TX_CFG_FIFO_EN
    // Offer held during a frame must be ignored
    begin
      logic quiet;
      send(16'd3, 2'd0, 2'd0, 1'b0, 8'h1F);
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      check("busy_ready", {31'b0, tx_ready}, 32'd0);
      check_frame("ignore", 16'h017E, 7, 4, -1);
      quiet = 1'b1;
      repeat (6) begin
        @(negedge clk);
        if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
      end
      check("ignore_idle", {31'b0, quiet}, 32'd1);
    end
`else
    // Five back-to-back pushes into a 4-deep FIFO
    begin
      logic [7:0] bytes [5];
      int fz;
      logic ok;
      logic [9:0] fr;
      bytes[0] = 8'h01; bytes[1] = 8'h80; bytes[2] = 8'hAA;
      bytes[3] = 8'h0F; bytes[4] = 8'hF0;
      cfg_div = 16'd3; cfg_data_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
      #1 cap_en = 1'b1;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check($sformatf("push%0d_ready", k), {31'b0, tx_ready}, 32'd1);
        tx_data  = bytes[k];
        tx_valid = 1'b1;
        @(posedge clk);
      end
      @(negedge clk);
      tx_valid = 1'b0;
      check("full_ready", {31'b0, tx_ready}, 32'd0);
      check("full_level", {29'b0, fifo_level}, 32'd4);
      repeat (210) @(negedge clk);
      cap_en = 1'b0;
      fz = -1;
      for (int j = 0; j < 20 && j < cap.size(); j++)
        if (fz < 0 && cap[j] == 1'b0) fz = j;
      check("fifo_first_start", fz, 32'd3);
      if (fz >= 0 && cap.size() > fz + 200) begin
        for (int f = 0; f < 5; f++) begin
          ok = 1'b1;
          fr = frame8n1(bytes[f]);
          for (int b = 0; b < 10; b++)
            for (int c = 0; c < 4; c++)
              if (cap[fz + f*40 + b*4 + c] !== fr[b]) ok = 1'b0;
          check($sformatf("b2b_frame%0d", f), {31'b0, ok}, 32'd1);
        end
        check("b2b_idle", {31'b0, cap[fz + 200]}, 32'd1);
      end else begin
        check("b2b_capture", 32'd0, 32'd1);
      end
      check("b2b_busy_end", {31'b0, busy}, 32'd0);
      check("b2b_level_end", {29'b0, fifo_level}, 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the baud divisor.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, power of two ≥2, TX FIFO entries; used only when the FIFO feature is compiled in.
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cfg_div, input, DIV_W, clocks-per-bit minus 1.
REQ-006 SHALL have port cfg_data_bits, input, 2: 0=5, 1=6, 2=7, 3=8 data bits.
REQ-007 SHALL have port cfg_parity, input, 2: 0=none, 1=even, 2=odd, 3=none.
REQ-008 SHALL have port cfg_stop2, input, 1: 0=one stop bit, 1=two stop bits.
REQ-009 SHALL have port tx_data, input, 8, byte to send, LSB first, upper unused bits ignored.
REQ-010 SHALL have port tx_valid, input, 1, producer offers tx_data.
REQ-011 SHALL have port tx_ready, output, 1, block accepts a byte this cycle.
REQ-012 SHALL have port tx, output, 1, serial line, idle high.
REQ-013 SHALL have port busy, output, 1, high from START through the last STOP clock.
REQ-014 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1, FIFO occupancy.

Function
REQ-015 SHALL transfer a byte on any rising clk edge with tx_valid && tx_ready.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP; on leaving IDLE, SHALL latch cfg_div, cfg_data_bits, cfg_parity, cfg_stop2 and the byte; config changes mid-frame have no effect.
REQ-017 SHALL hold each bit for exactly cfg_div+1 clocks; cfg_div < 3 is treated as 3.
REQ-018 SHALL send DATA bits 0..N-1 (N = 5..8); PARITY is skipped when parity = none.
REQ-019 SHALL compute parity over the N sent bits only: even = XOR, odd = ~XOR.
REQ-020 SHALL hold STOP high for 1 or 2 bit times, then go to IDLE, or directly to START if another byte is available (no idle gap).
REQ-021 SHALL register tx; tx SHALL fall one clock after the state enters START.
REQ-022 SHALL ignore tx_valid while tx_ready is low, and drop no byte that was accepted.

Reset
REQ-023 SHALL, while rst_n is low, force tx=1, busy=0, state=IDLE, counters=0, fifo_level=0; tx_ready=1 one clock after deassertion.
REQ-024 SHALL abort any frame on reset mid-frame and discard the FIFO contents; tx SHALL return high immediately.

Configuration
REQ-025 SHALL, with UART_TX_CFG_FIFO_EN defined, place a FIFO_DEPTH FIFO before the serializer: tx_ready = !full; the serializer pops when IDLE (or at the end of STOP) and the FIFO is not empty; a push and pop in the same cycle on a full FIFO are both accepted with the level unchanged; the first START occurs 2 clocks after a push into an empty idle block.
REQ-026 SHALL, without UART_TX_CFG_FIFO_EN, use a single holding register: tx_ready = (state == IDLE); START one clock after acceptance; fifo_level tied 0.

Structure
REQ-027 SHALL place the state enum, parity-mode encodings and data-bits decode constants in package uart_pkg.
REQ-028 SHALL implement the FIFO as sub-module uart_tx_fifo (sync, registered level), instantiated only under UART_TX_CFG_FIFO_EN.

Verification
REQ-029 SHALL verify: cfg_div=3, 8N1, byte 0x55 -> line 0,1,0,1,0,1,0,1,0,1, each bit 4 clocks, frame 40 clocks.
REQ-030 SHALL verify: cfg_div=7, 7 data bits, even parity, 2 stop, byte 0xFF -> 7 ones, parity 1, 16 clocks of stop high, busy low after.
REQ-031 SHALL verify: 5 data bits, odd parity, byte 0xE3 -> bits 1,1,0,0,0, parity 1; bits 7:5 are never transmitted.
REQ-032 SHALL verify: with FIFO_EN, FIFO_DEPTH=4, five back-to-back pushes -> tx_ready low after the 5th accept (4 queued + 1 in flight) and frames sent back-to-back with no idle clock.
REQ-033 SHALL verify: rst_n pulsed low during DATA bit 3 -> tx=1, busy=0, fifo_level=0; next byte sends a clean frame.
REQ-034 SHALL verify: cfg_div changed from 3 to 9 mid-frame -> current frame keeps 4-clock bits; next frame uses 10-clock bits.
